// File: rtl/regfile_sb.sv
// Integer register file with per-register busy scoreboard for RAW stall detection.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through of writeback data/busy clear to reads.
module regfile_sb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rdat1,
   output logic [XLEN-1:0] rdat2,
   output logic            busy1,
   output logic            busy2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdat,
   input  logic            flush,
   output logic [AW:0]     busy_cnt
);

   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0]  r_regs [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [CW-1:0]    r_busy_cnt;

   logic             w_wr_ok;
   logic             w_iss_ok;
   logic [NREGS-1:0] w_busy_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [XLEN-1:0]  w_rdat1;
   logic [XLEN-1:0]  w_rdat2;
   logic             w_busy1;
   logic             w_busy2;

   // Register 0 is neither written nor marked busy when hardwired.
   assign w_wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
   assign w_iss_ok = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

   // Writeback clears, a new issue re-marks (new producer wins), flush overrides both.
   always_comb begin
      w_busy_nxt = r_busy;
      w_cnt_nxt  = '0;
      if (w_wr_ok) begin
         w_busy_nxt[waddr] = 1'b0;
      end
      if (w_iss_ok) begin
         w_busy_nxt[issue_rd] = 1'b1;
      end
      if (flush) begin
         w_busy_nxt = '0;
      end
      for (int i = 0; i < NREGS; i++) begin
         w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         if (w_wr_ok) begin
            r_regs[waddr] <= wdat;
         end
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
      end
   end

   // Read port 1
   always_comb begin
      w_rdat1 = r_regs[rs1];
      w_busy1 = r_busy[rs1];
      if ((ZERO_REG != 0) && (rs1 == '0)) begin
         w_rdat1 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (waddr == rs1)) begin
         w_rdat1 = wdat;
         if (!(w_iss_ok && (issue_rd == rs1))) begin
            w_busy1 = 1'b0;
         end
      end
`endif
   end

   // Read port 2
   always_comb begin
      w_rdat2 = r_regs[rs2];
      w_busy2 = r_busy[rs2];
      if ((ZERO_REG != 0) && (rs2 == '0)) begin
         w_rdat2 = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (waddr == rs2)) begin
         w_rdat2 = wdat;
         if (!(w_iss_ok && (issue_rd == rs2))) begin
            w_busy2 = 1'b0;
         end
      end
`endif
   end

   assign rdat1    = w_rdat1;
   assign rdat2    = w_rdat2;
   assign busy1    = w_busy1;
   assign busy2    = w_busy2;
   assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a random scoreboard run.
module tb_regfile_sb;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   rs1, rs2, issue_rd, waddr;
   logic [XLEN-1:0] rdat1, rdat2, wdat;
   logic            busy1, busy2, issue_valid, we, flush;
   logic [AW:0]     busy_cnt;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rdat1(rdat1), .rdat2(rdat2),
      .busy1(busy1), .busy2(busy2), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .we(we), .waddr(waddr), .wdat(wdat), .flush(flush), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        b1;
      logic        b2;
      logic [5:0]  cnt;
   } exp_t;

   exp_t            sb_q[$];
   logic [31:0]     m_regs [NREGS];
   logic [NREGS-1:0] m_busy;
   int              n_tests = 0;
   int              n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_rd(input logic [AW-1:0] a);
      logic [31:0] v;
      v = (a == '0) ? 32'h0 : m_regs[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && we && (a == waddr) && (a != '0)) v = wdat;
`endif
      return v;
   endfunction

   function automatic logic m_bz(input logic [AW-1:0] a);
      logic b;
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && we && (a == waddr) && (a != '0) && !(issue_valid && (issue_rd == a))) b = 1'b0;
`endif
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      m_busy = '0;
   endtask

   // Push the expectation for the current inputs, then pop and compare once outputs settle.
   task automatic probe(input string tag);
      exp_t e;
      sb_q.push_back('{tag, m_rd(rs1), m_rd(rs2), m_bz(rs1), m_bz(rs2), 6'($countones(m_busy))});
      #2;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check_val({e.tag, "_rdat1"}, 64'(rdat1), 64'(e.d1));
         check_val({e.tag, "_rdat2"}, 64'(rdat2), 64'(e.d2));
         check_val({e.tag, "_busy1"}, 64'(busy1), 64'(e.b1));
         check_val({e.tag, "_busy2"}, 64'(busy2), 64'(e.b2));
         check_val({e.tag, "_cnt"},   64'(busy_cnt), 64'(e.cnt));
      end
   endtask

   task automatic tick();
      if (rst_n) begin
         if (we && (waddr != '0)) begin
            m_regs[waddr] = wdat;
            m_busy[waddr] = 1'b0;
         end
         if (issue_valid && (issue_rd != '0)) m_busy[issue_rd] = 1'b1;
         if (flush) m_busy = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 1'b0; issue_valid = 1'b0; flush = 1'b0;
      waddr = '0; issue_rd = '0; wdat = '0;
   endtask

   initial begin
      rst_n = 1'b0; rs1 = '0; rs2 = '0;
      idle();
      model_reset();
      #12;
      rs1 = 5'd5; rs2 = 5'd31;
      probe("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Write then read back; write to reg 0 discarded
      we = 1'b1; waddr = 5'd5; wdat = 32'hDEADBEEF;
      tick(); idle(); rs1 = 5'd5;
      probe("wr5");
      check_val("wr5_const", 64'(rdat1), 64'h0000_0000_DEAD_BEEF);
      we = 1'b1; waddr = 5'd0; wdat = 32'h1234;
      tick(); idle(); rs2 = 5'd0;
      probe("wr0");
      check_val("wr0_const", 64'(rdat2), 64'h0);

      // Issue marks busy, writeback clears
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick(); idle(); rs1 = 5'd7;
      probe("iss7");
      check_val("iss7_busy_const", 64'(busy1), 64'd1);
      check_val("iss7_cnt_const", 64'(busy_cnt), 64'd1);
      we = 1'b1; waddr = 5'd7; wdat = 32'h77;
      tick(); idle();
      probe("wb7");
      check_val("wb7_cnt_const", 64'(busy_cnt), 64'd0);

      // Same-edge issue and write, then flush beating issue
      issue_valid = 1'b1; issue_rd = 5'd9; we = 1'b1; waddr = 5'd9; wdat = 32'h55;
      tick(); idle(); rs1 = 5'd9;
      probe("iss_wr9");
      check_val("iss_wr9_data_const", 64'(rdat1), 64'h55);
      check_val("iss_wr9_busy_const", 64'(busy1), 64'd1);
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3; rs2 = 5'd3;
      tick(); idle();
      probe("flush");
      check_val("flush_cnt_const", 64'(busy_cnt), 64'd0);
      check_val("flush_busy3_const", 64'(busy2), 64'd0);

      // Bypass visibility in the write cycle
      rs1 = 5'd4; we = 1'b1; waddr = 5'd4; wdat = 32'hA5A5A5A5;
      probe("byp4");
`ifdef REGFILE_BYPASS_EN
      check_val("byp4_same_const", 64'(rdat1), 64'hA5A5A5A5);
`else
      check_val("byp4_same_const", 64'(rdat1), 64'h0);
`endif
      tick(); idle();
      probe("byp4_next");
      check_val("byp4_next_const", 64'(rdat1), 64'hA5A5A5A5);
      rs2 = 5'd4; issue_valid = 1'b1; issue_rd = 5'd4; we = 1'b1; waddr = 5'd4; wdat = 32'h1;
      probe("byp4_iss");
      tick(); idle();
      probe("byp4_iss_next");

      // Fill the scoreboard, then async reset mid-cycle drops a pending write
      for (int r = 1; r < NREGS; r++) begin
         issue_valid = 1'b1; issue_rd = 5'(r);
         tick();
      end
      idle();
      probe("all_busy");
      check_val("all_busy_cnt_const", 64'(busy_cnt), 64'd31);
      we = 1'b1; waddr = 5'd10; wdat = 32'hCAFE; rs1 = 5'd11; rs2 = 5'd0;
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      probe("rst_mid");
      check_val("rst_mid_cnt_const", 64'(busy_cnt), 64'd0);
      tick();
      idle();
      rst_n = 1'b1;
      rs1 = 5'd10; rs2 = 5'd5;
      probe("rst_lost");
      check_val("rst_lost_const", 64'(rdat1), 64'h0);

      // Random mixed traffic against the model
      for (int c = 0; c < 300; c++) begin
         we          = ($urandom_range(0, 2) != 0);
         waddr       = 5'($urandom_range(0, 7));
         wdat        = $urandom();
         issue_valid = ($urandom_range(0, 1) != 0);
         issue_rd    = 5'($urandom_range(0, 7));
         flush       = ($urandom_range(0, 15) == 0);
         rs1         = 5'($urandom_range(0, 7));
         rs2         = 5'($urandom_range(0, 7));
         probe("rand");
         tick();
      end
      idle();
      probe("final");

      check_val("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
